// File: rtl/mac4_pkg.sv
// Shared types and timing constants for the 4-lane MAC sequencer.
package mac4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Operand buffer read latency and PE register latency, in cycles.
    localparam int MAC4_RD_LAT = 1;
    localparam int MAC4_PE_LAT = 1;

    // Cycles between the last read issue and the final PE sum being valid.
    localparam int MAC4_DRAIN_LEN = MAC4_RD_LAT + MAC4_PE_LAT;

endpackage

// File: rtl/mac4_addr_gen.sv
// Operand address generator: holds the job's base addresses, group count
// and current group index; addresses wrap modulo 2^ADDR_WIDTH.
module mac4_addr_gen #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] feat_base,
    input  logic [ADDR_WIDTH-1:0] wgt_base,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic [ADDR_WIDTH-1:0] feat_addr,
    output logic [ADDR_WIDTH-1:0] wgt_addr,
    output logic                  first_grp,
    output logic                  last_grp
);

    logic [ADDR_WIDTH-1:0] feat_base_q;
    logic [ADDR_WIDTH-1:0] wgt_base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  grp;

    // Latch the job on load, then step the group index once per issued read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            feat_base_q <= '0;
            wgt_base_q  <= '0;
            len_q       <= '0;
            grp         <= '0;
        end else if (load) begin
            feat_base_q <= feat_base;
            wgt_base_q  <= wgt_base;
            len_q       <= len;
            grp         <= '0;
        end else if (advance) begin
            grp <= grp + LEN_WIDTH'(1);
        end
    end

    assign feat_addr = feat_base_q + ADDR_WIDTH'(grp);
    assign wgt_addr  = wgt_base_q + ADDR_WIDTH'(grp);
    assign first_grp = (grp == '0);
    // Only consulted while issuing, where len_q is at least 1.
    assign last_grp  = (grp == len_q - LEN_WIDTH'(1));

endmodule

// File: rtl/mac4_seq_ctrl.sv
// Sequencer for one 4-lane MAC PE: issues operand reads for len groups,
// drives the PE acc control, and returns the final sum on a result port.
// Optional macro MAC4_SEQ_PERF_EN adds saturating busy/stall counters.
//
// Handshakes (start_*, res_*): a transfer happens on a rising clk edge where
// valid && ready are both 1; the sender holds valid and its payload stable
// until that edge, and ready never depends combinationally on valid.
module mac4_seq_ctrl
    import mac4_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int LEN_WIDTH    = 8,
    parameter int PE_OUT_WIDTH = 16
`ifdef MAC4_SEQ_PERF_EN
    , parameter int PERF_WIDTH = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [ADDR_WIDTH-1:0]   feat_base,
    input  logic [ADDR_WIDTH-1:0]   wgt_base,
    input  logic [LEN_WIDTH-1:0]    len,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   feat_addr,
    output logic [ADDR_WIDTH-1:0]   wgt_addr,
    output logic                    mac_acc,
    input  logic [PE_OUT_WIDTH-1:0] mac_sum,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [PE_OUT_WIDTH-1:0] res_data,
    output logic                    busy,
    output state_t                  dbg_state
`ifdef MAC4_SEQ_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0]   perf_busy_cyc,
    output logic [PERF_WIDTH-1:0]   perf_stall_cyc
`endif
);

    localparam logic [1:0] DRAIN_LAST = 2'(MAC4_DRAIN_LEN - 1);

    state_t     state;
    logic [1:0] drain_cnt;
    logic       start_fire;
    logic       first_grp;
    logic       last_grp;
    logic       ag_load;
    logic       ag_advance;

    assign start_fire = (state == IDLE) && start_valid && start_ready;
    assign ag_load    = start_fire;
    assign ag_advance = (state == ISSUE) && !last_grp;
    assign dbg_state  = state;

    mac4_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ag_load),
        .advance   (ag_advance),
        .feat_base (feat_base),
        .wgt_base  (wgt_base),
        .len       (len),
        .feat_addr (feat_addr),
        .wgt_addr  (wgt_addr),
        .first_grp (first_grp),
        .last_grp  (last_grp)
    );

    // Job FSM with registered handshake, read strobe and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            rd_en       <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_fire) begin
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (len == '0) begin
                            // Empty dot product: nothing to read, result is zero.
                            state     <= HOLD;
                            res_data  <= '0;
                            res_valid <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            rd_en <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (last_grp) begin
                        state     <= DRAIN;
                        rd_en     <= 1'b0;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    // Wait out read + PE latency so mac_sum includes the last group.
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= HOLD;
                        res_data  <= mac_sum;
                        res_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delay the accumulate flag by the read latency so it lines up with PE data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mac_acc <= 1'b0;
        end else begin
            mac_acc <= rd_en && !first_grp;
        end
    end

`ifdef MAC4_SEQ_PERF_EN
    // Saturating busy-cycle and result-stall counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && (perf_busy_cyc != '1)) begin
                perf_busy_cyc <= perf_busy_cyc + PERF_WIDTH'(1);
            end
            if ((state == HOLD) && !res_ready && (perf_stall_cyc != '1)) begin
                perf_stall_cyc <= perf_stall_cyc + PERF_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mac4_seq_ctrl.sv
// Testbench for mac4_seq_ctrl with a behavioural operand buffer + 4-lane PE.
module tb_mac4_seq_ctrl;
    import mac4_pkg::*;

    localparam int AW = 10;
    localparam int LW = 8;
    localparam int PW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start_valid;
    logic          start_ready;
    logic [AW-1:0] feat_base;
    logic [AW-1:0] wgt_base;
    logic [LW-1:0] len;
    logic          rd_en;
    logic [AW-1:0] feat_addr;
    logic [AW-1:0] wgt_addr;
    logic          mac_acc;
    logic [PW-1:0] mac_sum;
    logic          res_valid;
    logic          res_ready;
    logic [PW-1:0] res_data;
    logic          busy;
    state_t        dbg_state;

    mac4_seq_ctrl #(
        .ADDR_WIDTH   (AW),
        .LEN_WIDTH    (LW),
        .PE_OUT_WIDTH (PW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .feat_base   (feat_base),
        .wgt_base    (wgt_base),
        .len         (len),
        .rd_en       (rd_en),
        .feat_addr   (feat_addr),
        .wgt_addr    (wgt_addr),
        .mac_acc     (mac_acc),
        .mac_sum     (mac_sum),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // ---------------- operand buffers + PE model ----------------
    logic [31:0]   fmem [1024];
    logic [31:0]   wmem [1024];
    logic [31:0]   f_q;
    logic [31:0]   w_q;
    logic [PW-1:0] pe_sum;

    function automatic logic [PW-1:0] dot4(input logic [31:0] a, input logic [31:0] b);
        logic [PW-1:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s = s + PW'(a[8*i +: 8]) * PW'(b[8*i +: 8]);
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (rd_en) begin
            f_q <= fmem[feat_addr];
            w_q <= wmem[wgt_addr];
        end
        pe_sum <= (mac_acc ? pe_sum : '0) + dot4(f_q, w_q);
    end
    assign mac_sum = pe_sum;

    function automatic logic [PW-1:0] dot_model(input logic [AW-1:0] fb, input logic [AW-1:0] wb,
                                                input logic [LW-1:0] n);
        logic [PW-1:0] s;
        logic [AW-1:0] fa;
        logic [AW-1:0] wa;
        s = '0;
        for (int g = 0; g < int'(n); g++) begin
            fa = fb + AW'(g);
            wa = wb + AW'(g);
            s  = s + dot4(fmem[fa], wmem[wa]);
        end
        return s;
    endfunction

    // ---------------- scoreboard ----------------
    logic [PW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [AW-1:0] fb;
        logic [AW-1:0] wb;
        logic [LW-1:0] len;
        int            hold;
        logic [PW-1:0] exp_sum;
    } vec_t;

    vec_t tbl[7];

    // ---------------- driver ----------------
    task automatic run_job(input vec_t v);
        logic [PW-1:0] d0;
        logic [PW-1:0] e;
        logic [AW-1:0] ea;
        int waited;
        int lat;
        lat = (v.len == '0) ? 1 : int'(v.len) + 3;
        feat_base   = v.fb;
        wgt_base    = v.wb;
        len         = v.len;
        start_valid = 1'b1;
        waited = 0;
        while (!start_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("start_ready_wait", 32'(start_ready), 32'd1);
        if (!start_ready) begin
            start_valid = 1'b0;
            return;
        end
        exp_q.push_back(v.exp_sum);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            chk("rd_en", 32'(rd_en), 32'(k <= int'(v.len)));
            if (rd_en && k <= int'(v.len)) begin
                ea = v.fb + AW'(k - 1);
                chk("feat_addr", 32'(feat_addr), 32'(ea));
                ea = v.wb + AW'(k - 1);
                chk("wgt_addr", 32'(wgt_addr), 32'(ea));
            end
            chk("mac_acc", 32'(mac_acc), 32'(k >= 3 && k <= int'(v.len) + 1));
            chk("res_valid_lat", 32'(res_valid), 32'(k == lat));
            chk("busy", 32'(busy), 32'd1);
            chk("start_ready_busy", 32'(start_ready), 32'd0);
        end
        d0 = res_data;
        // Backpressure: result must hold steady and new starts must be ignored.
        for (int h = 0; h < v.hold; h++) begin
            start_valid = 1'b1;
            len         = 8'd1;
            @(negedge clk);
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", 32'(res_data), 32'(d0));
            chk("hold_start_ready", 32'(start_ready), 32'd0);
            chk("hold_rd_en", 32'(rd_en), 32'd0);
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_res: got 0x%0h expected nothing (queue empty)", res_data);
        end else begin
            checks--;
            e = exp_q.pop_front();
            chk("res_data", 32'(res_data), 32'(e));
        end
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_done", 32'(res_valid), 32'd0);
        chk("start_ready_done", 32'(start_ready), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        int stray;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        feat_base   = '0;
        wgt_base    = '0;
        len         = '0;
        f_q         = '0;
        w_q         = '0;
        for (int i = 0; i < 1024; i++) begin
            fmem[i] = $urandom;
            wmem[i] = $urandom;
        end
        for (int i = 0; i < 4; i++) begin
            fmem[10'h010 + i] = 32'h0101_0101;
            wmem[10'h200 + i] = 32'h0101_0101;
        end

        tbl[0] = '{10'h010, 10'h200, 8'd4, 0, 16'd16};
        tbl[1] = '{10'h040, 10'h140, 8'd1, 0, 16'd0};
        tbl[2] = '{10'h100, 10'h100, 8'd0, 0, 16'd0};
        tbl[3] = '{10'h080, 10'h300, 8'd5, 5, 16'd0};
        tbl[4] = '{10'h020, 10'h220, 8'd6, 0, 16'd0};
        tbl[5] = '{10'h3FE, 10'h3FF, 8'd3, 2, 16'd0};
        tbl[6] = '{10'h123, 10'h0AB, 8'd2, 1, 16'd0};
        tbl[1].exp_sum = dot_model(tbl[1].fb, tbl[1].wb, tbl[1].len);
        for (int i = 3; i < 7; i++) begin
            tbl[i].exp_sum = dot_model(tbl[i].fb, tbl[i].wb, tbl[i].len);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_mac_acc", 32'(mac_acc), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_feat_addr", 32'(feat_addr), 32'd0);
        chk("rst_wgt_addr", 32'(wgt_addr), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i]);
        end

        // Reset in the middle of ISSUE abandons the job.
        feat_base   = 10'h000;
        wgt_base    = 10'h000;
        len         = 8'd10;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        chk("mid_issue_rd_en", 32'(rd_en), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_mid_rd_en", 32'(rd_en), 32'd0);
        chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
        chk("rst_mid_start_ready", 32'(start_ready), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (res_valid || rd_en) stray++;
        end
        chk("no_stray_result", 32'(stray), 32'd0);

        // A normal job still works after the abort.
        run_job(tbl[6]);
        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
